// File: rtl/dooz_pkg.sv
// dooz_pkg: shared widths, states and rejection codes for the dooz move entry
package dooz_pkg;
  localparam int NCELLS = 9;
  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] NO_MOVE = 4'd0;
  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_e;
  localparam logic [1:0] MULTI    = 2'd1;
  localparam logic [1:0] NOT_TURN = 2'd2;
  localparam logic [1:0] OCCUPIED = 2'd3;
  function automatic logic [CODE_W-1:0] cell_code(input logic [NCELLS-1:0] v);
    cell_code = NO_MOVE;
    for (int i = 0; i < NCELLS; i++) if (v[i]) cell_code = CODE_W'(i + 1);
  endfunction
endpackage

// File: rtl/dooz_debounce.sv
// dooz_debounce: single-bit debouncer accepting a level after DEB_CYCLES stable cycles
module dooz_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic raw_i,
  output logic level_o
);
  logic             level_q, level_d, flip;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // count cycles of disagreement; flip the level once it has persisted long enough
  always_comb begin
    flip    = !clr_i && (raw_i != level_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));
    level_d = clr_i ? 1'b0 : (flip ? raw_i : level_q);
    cnt_d   = (clr_i || raw_i == level_q || flip) ? '0 : cnt_q + 1'b1;
  end
  // level and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end
  assign level_o = level_q;
endmodule

// File: rtl/dooz_move_entry.sv
// dooz_move_entry: debounced, validated cell-press entry driving the dooz controller's p1/p2 moves
module dooz_move_entry
  import dooz_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NCELLS-1:0] key,
  input  logic              turnA,
  input  logic              turnB,
  input  logic [NCELLS-1:0] selectA,
  input  logic [NCELLS-1:0] selectB,
  input  logic              winnerA,
  input  logic              winnerB,
  input  logic              equal,
  output logic [CODE_W-1:0] p1,
  output logic [CODE_W-1:0] p2,
  output logic              move_ok,
  output logic              move_rej,
  output logic [1:0]        rej_code
);
  state_e            state_q, state_d;
  logic [NCELLS-1:0] deb, deb_prev_q, sel_q, sel_d;
  logic [CODE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic              ok_q, ok_d, rej_q, rej_d;
  logic [1:0]        code_q, code_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d, tmo_inc;
  logic              game_over, bad_turn, multi, press, occ_hit, reject, ack, timeout;

  for (genvar i = 0; i < NCELLS; i++) begin : g_deb
    dooz_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (start),
      .raw_i  (key[i]),
      .level_o(deb[i])
    );
  end

  assign game_over = winnerA | winnerB | equal;
  assign bad_turn  = game_over || (turnA == turnB);
  assign multi     = (deb & (deb - 1'b1)) != '0;
  assign press     = (deb_prev_q == '0) && (deb != '0);
  assign occ_hit   = |(deb & (selectA | selectB));
  assign reject    = press && (multi || bad_turn || occ_hit);
  assign ack       = |(sel_q & ((p1_q != NO_MOVE) ? selectA : selectB));
  assign tmo_inc   = tmo_q + 1'b1;
  assign timeout   = tmo_inc == CNT_W'(ACK_TIMEOUT);

  // validate fresh presses, hold the driven move until acknowledged, then wait for key release
  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    sel_d   = sel_q;
    ok_d    = 1'b0;
    rej_d   = 1'b0;
    code_d  = code_q;
    tmo_d   = '0;
    case (state_q)
      IDLE: begin
        rej_d  = reject;
        code_d = reject ? (multi ? MULTI : bad_turn ? NOT_TURN : OCCUPIED) : code_q;
        if (reject) state_d = RELEASE;
        else if (press) begin
          sel_d   = deb;
          p1_d    = turnA ? cell_code(deb) : NO_MOVE;
          p2_d    = turnA ? NO_MOVE : cell_code(deb);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        tmo_d = tmo_inc;
        if (ack || game_over || timeout) begin
          p1_d    = NO_MOVE;
          p2_d    = NO_MOVE;
          tmo_d   = '0;
          ok_d    = ack;
          rej_d   = !ack;
          code_d  = ack ? code_q : NOT_TURN;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = (deb == '0) ? IDLE : RELEASE;
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = IDLE;
      p1_d    = NO_MOVE;
      p2_d    = NO_MOVE;
      sel_d   = '0;
      ok_d    = 1'b0;
      rej_d   = 1'b0;
      code_d  = 2'd0;
      tmo_d   = '0;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      p1_q       <= NO_MOVE;
      p2_q       <= NO_MOVE;
      sel_q      <= '0;
      ok_q       <= 1'b0;
      rej_q      <= 1'b0;
      code_q     <= 2'd0;
      tmo_q      <= '0;
      deb_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      sel_q      <= sel_d;
      ok_q       <= ok_d;
      rej_q      <= rej_d;
      code_q     <= code_d;
      tmo_q      <= tmo_d;
      deb_prev_q <= start ? '0 : deb;
    end
  end

  assign p1       = p1_q;
  assign p2       = p2_q;
  assign move_ok  = ok_q;
  assign move_rej = rej_q;
  assign rej_code = code_q;
endmodule

// File: doc/dooz_move_entry.md
Name: dooz_move_entry

Overview:
- Player-side front end for the dooz (tic-tac-toe) game controller.
- Debounces nine raw cell buttons and validates each press against the current board, whose turn it is, and whether the game is over.
- Drives the move code onto p1 or p2 (the game controller's move inputs) and holds it until the controller acknowledges by marking the cell.
- Sits between the board's physical buttons and the game controller. It is the transmitting end of the controller's move interface.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles before a raw key level is accepted.
- ACK_TIMEOUT, 64: cycles to wait for the board to show the driven cell before abandoning the move.
- CNT_W, 8: width of the debounce and timeout counters. Must hold max(DEB_CYCLES, ACK_TIMEOUT).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  new-game strobe, same as the controller's start. Synchronously clears the block.
- key  in  9  raw cell buttons, active-high. Bit i corresponds to cell code i+1.
- turnA  in  1  controller: player A to move.
- turnB  in  1  controller: player B to move.
- selectA  in  9  controller: cells owned by A. Bit i corresponds to code i+1.
- selectB  in  9  controller: cells owned by B.
- winnerA  in  1  controller: A has won.
- winnerB  in  1  controller: B has won.
- equal  in  1  controller: draw.
- p1  out  4  move code for A. 0 means no move, 1..9 is a cell.
- p2  out  4  move code for B. Same encoding.
- move_ok  out  1  one-cycle pulse when the controller accepts a driven move.
- move_rej  out  1  one-cycle pulse when a press is rejected or a move times out.
- rej_code  out  2  reason for the last rejection. Holds until the next rejection.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - p1=0, p2=0, move_ok=0, move_rej=0, rej_code=0;
  - all debounced levels 0, all counters 0;
  - state IDLE.
- start=1 has the same effect, but synchronously. It overrides every other event in that cycle.
- Debounce is per key:
  - The counter increments while raw differs from the debounced level and clears when they match.
  - When the counter reaches DEB_CYCLES-1 and raw still differs, the debounced level flips and the counter clears.
  - Effect: a level change is accepted after exactly DEB_CYCLES stable cycles.
- game_over = winnerA | winnerB | equal.
- occupied = selectA | selectB.
- States: IDLE, DRIVE, RELEASE.
- IDLE: evaluates only in a cycle where the debounced vector changes from all-zero to non-zero. Checks in priority order:
  - More than one debounced bit set: reject, rej_code=1 (MULTI).
  - game_over=1, or turnA==turnB: reject, rej_code=2 (NOT_TURN).
  - occupied[idx]=1: reject, rej_code=3 (OCCUPIED).
  - Otherwise accept: code=idx+1 is registered into p1 if turnA, else into p2. The other port stays 0. Go to DRIVE.
  - Rejection: move_rej pulses in the next cycle, then go to RELEASE.
- Code timing: p1/p2 become valid on the clock edge after the debounced edge. That is DEB_CYCLES+1 cycles after the raw press becomes stable.
- DRIVE: holds the code steady. Acknowledgement is the matching bit appearing in the driving player's select vector (selectA[idx] for p1, selectB[idx] for p2).
  - On ack: clear p1/p2 to 0, pulse move_ok for 1 cycle, go to RELEASE.
  - The timeout counter counts DRIVE cycles. When it reaches ACK_TIMEOUT with no ack: clear p1/p2, pulse move_rej with rej_code=2, go to RELEASE.
  - If game_over rises during DRIVE without an ack: same as timeout, taken immediately.
  - Key activity during DRIVE is ignored.
- RELEASE: waits until the debounced vector is all-zero, then returns to IDLE. This blocks auto-repeat and presses made while the key is still held.
- p1 and p2 are never non-zero at the same time. Codes 10..15 are never driven.
- move_ok and move_rej are never asserted in the same cycle.

Decomposition:
- Package dooz_pkg holds:
  - NCELLS=9, CODE_W=4, NO_MOVE=4'd0;
  - state enum {IDLE, DRIVE, RELEASE};
  - rej_code constants MULTI=1, NOT_TURN=2, OCCUPIED=3.
- One sub-module, dooz_debounce: a single-bit debouncer with parameters DEB_CYCLES and CNT_W, instantiated nine times.
- Index encoding, validation and the FSM stay in dooz_move_entry.

Test Plan:
- Reset, then start pulse, with turnA=1 and an empty board. Hold key[8] high for 10 cycles -> p1=9 exactly 5 cycles after key rises, p2=0. Set selectA[8]=1 -> next cycle p1=0 and move_ok pulses once.
- key[4] bounces 1,0,1 on alternate cycles, then stays high, with turnB=1 -> a single p2=5 only after 4 stable cycles; no move_rej.
- selectA=9'h100, turnB=1, press key[8] -> move_rej with rej_code=3; p1 and p2 stay 0; a second press is ignored until the key is released.
- Press key[0] and key[1] together -> move_rej with rej_code=1.
- winnerA=1, press key[2] -> rejected with rej_code=2.
- Accept p1=7, then never set selectA[6] -> at cycle 64 of DRIVE, p1=0 and move_rej pulses. Separately: pull reset low while p2=3 is being driven -> p2=0 immediately, asynchronously.
